// File: rtl/pipe_ctrl_seq.sv
// Stateful pipeline controller: per-stage stall/flush, PC stall and redirect,
// multi-cycle EXE tracking with timeout, sticky halt, and perf counters.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   stall_req_i[NSTAGE]    per-stage stall requests (0=IF .. 4=WB)
//   redirect_i, redirect_addr_i   taken jump/branch from stage REDIR_IDX
//   mc_start_i, mc_done_i  multi-cycle unit handshake in stage EXE_IDX
//   halt_req_i, resume_i   enter / leave HALTED
//   stallpc_o, stall_o, flush_o   pipeline hold / bubble controls
//   je_o, jump_addr_o      PC redirect
//   halted_o, mc_timeout_o status
//   cyc_cnt_o, stall_cnt_o, flush_cnt_o   performance counters
module pipe_ctrl_seq #(
   parameter int XLEN       = 32,
   parameter int NSTAGE     = 5,
   parameter int EXE_IDX    = 2,
   parameter int REDIR_IDX  = 2,
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NSTAGE-1:0] stall_req_i,
   input  logic              redirect_i,
   input  logic [XLEN-1:0]   redirect_addr_i,
   input  logic              mc_start_i,
   input  logic              mc_done_i,
   input  logic              halt_req_i,
   input  logic              resume_i,
   output logic              stallpc_o,
   output logic [NSTAGE-1:0] stall_o,
   output logic [NSTAGE-1:0] flush_o,
   output logic              je_o,
   output logic [XLEN-1:0]   jump_addr_o,
   output logic              halted_o,
   output logic              mc_timeout_o,
   output logic [CNT_W-1:0]  cyc_cnt_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   localparam logic [1:0] RUN     = 2'd0;
   localparam logic [1:0] MC_BUSY = 2'd1;
   localparam logic [1:0] HALTED  = 2'd2;

   localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
   localparam int BW = $clog2(MC_TIMEOUT + 1);
   localparam logic [BW-1:0] BUSY_LAST = BW'(MC_TIMEOUT - 1);
   localparam logic [BW-1:0] BUSY_ONE  = BW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]        state;
   logic              halt_pend;
   logic [BW-1:0]     busy_cnt;
   logic              pend_v;
   logic [XLEN-1:0]   pend_addr;

   logic [NSTAGE-1:0] svec;
   logic              any_stall;
   logic [IW-1:0]     top;
   logic              mc_stall;
   logic              eligible;
   logic              halted;
   logic              busy_exit;
   logic              halt_next;

   assign halted = (state == HALTED);

   // The multi-cycle unit holds EXE from the start cycle until done arrives.
   assign mc_stall = ((state == RUN) && mc_start_i && !mc_done_i) ||
                     ((state == MC_BUSY) && !mc_done_i);

   always_comb begin
      svec = stall_req_i;
      if (mc_stall) svec[EXE_IDX] = 1'b1;
      any_stall = |svec;
      top = '0;
      for (int k = 0; k < NSTAGE; k++) begin
         if (svec[k]) top = IW'(k);
      end
   end

   // A redirect may only go out when nothing at or beyond its own stage
   // is stalled; otherwise it waits in the pending register.
   assign eligible = !halted && (redirect_i || pend_v) &&
                     (!any_stall || (int'(top) < REDIR_IDX));

   always_comb begin
      stall_o     = '0;
      flush_o     = '0;
      stallpc_o   = 1'b0;
      je_o        = 1'b0;
      jump_addr_o = '0;
      if (rst_i) begin
         flush_o = '1;
      end else if (halted) begin
         stall_o   = '1;
         stallpc_o = 1'b1;
      end else begin
         if (any_stall) begin
            stallpc_o = 1'b1;
            for (int j = 0; j < NSTAGE; j++) begin
               if (j <= int'(top)) stall_o[j] = 1'b1;
               if (j == int'(top) + 1) flush_o[j] = 1'b1;
            end
         end
         if (eligible) begin
            je_o        = 1'b1;
            jump_addr_o = redirect_i ? redirect_addr_i : pend_addr;
            stallpc_o   = 1'b0;
            for (int j = 0; j < NSTAGE; j++) begin
               if (j < REDIR_IDX) begin
                  flush_o[j] = 1'b1;
                  stall_o[j] = 1'b0;
               end
            end
         end
      end
   end

   assign halt_next = halt_pend || halt_req_i;
   assign busy_exit = mc_done_i || (busy_cnt == BUSY_LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= RUN;
         halt_pend    <= 1'b0;
         busy_cnt     <= '0;
         mc_timeout_o <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (mc_start_i && !mc_done_i) begin
                  state     <= MC_BUSY;
                  busy_cnt  <= '0;
                  halt_pend <= halt_req_i;
               end else if (halt_next) begin
                  state     <= HALTED;
                  halt_pend <= 1'b0;
               end
            end
            MC_BUSY: begin
               if (busy_exit) begin
                  if (!mc_done_i) mc_timeout_o <= 1'b1;
                  state     <= halt_next ? HALTED : RUN;
                  halt_pend <= 1'b0;
                  busy_cnt  <= '0;
               end else begin
                  busy_cnt  <= busy_cnt + BUSY_ONE;
                  halt_pend <= halt_next;
               end
            end
            HALTED: begin
               if (resume_i && !halt_req_i) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_v    <= 1'b0;
         pend_addr <= '0;
      end else if (eligible) begin
         pend_v <= 1'b0;
      end else if (redirect_i) begin
         pend_v    <= 1'b1;
         pend_addr <= redirect_addr_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cyc_cnt_o   <= '0;
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         if (!halted) cyc_cnt_o <= cyc_cnt_o + CNT_ONE;
         if (!halted && stallpc_o) stall_cnt_o <= stall_cnt_o + CNT_ONE;
         if (je_o) flush_cnt_o <= flush_cnt_o + CNT_ONE;
      end
   end

   assign halted_o = halted;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Scoreboard bench for pipe_ctrl_seq: expected outputs are queued per
// driven cycle and compared on the falling edge.
module tb_pipe_ctrl_seq;

   localparam int TMO = 12;

   typedef struct {
      logic        rst;
      logic [4:0]  st;
      logic [4:0]  fl;
      logic        spc;
      logic        je;
      logic [31:0] ja;
      logic        hl;
      logic        tmo;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  sreq;
   logic        redir;
   logic [31:0] raddr;
   logic        mcs, mcd, hreq, res;
   logic        stallpc, je, halted, tmo;
   logic [4:0]  stall, flush;
   logic [31:0] jaddr, cyc_cnt, stall_cnt, flush_cnt;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   logic        exp_tmo = 1'b0;
   logic        cnt_ok = 1'b0;
   logic [31:0] m_cyc = 0, m_stall = 0, m_flush = 0;

   always #5 clk = ~clk;

   pipe_ctrl_seq #(.MC_TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_i(rst), .stall_req_i(sreq),
      .redirect_i(redir), .redirect_addr_i(raddr),
      .mc_start_i(mcs), .mc_done_i(mcd),
      .halt_req_i(hreq), .resume_i(res),
      .stallpc_o(stallpc), .stall_o(stall), .flush_o(flush),
      .je_o(je), .jump_addr_o(jaddr), .halted_o(halted),
      .mc_timeout_o(tmo), .cyc_cnt_o(cyc_cnt),
      .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("stall", 32'(stall), 32'(e.st));
         chk("flush", 32'(flush), 32'(e.fl));
         chk("stallpc", 32'(stallpc), 32'(e.spc));
         chk("je", 32'(je), 32'(e.je));
         if (e.je) chk("jaddr", jaddr, e.ja);
         if (e.rst) chk("jaddr_rst", jaddr, 32'h0);
         chk("halted", 32'(halted), 32'(e.hl));
         chk("tmo", 32'(tmo), 32'(e.tmo));
         if (cnt_ok) begin
            chk("cyc_cnt", cyc_cnt, m_cyc);
            chk("stall_cnt", stall_cnt, m_stall);
            chk("flush_cnt", flush_cnt, m_flush);
         end
         if (e.rst) begin
            m_cyc = 0; m_stall = 0; m_flush = 0;
            cnt_ok = 1'b1;
         end else begin
            if (!e.hl) m_cyc++;
            if (!e.hl && e.spc) m_stall++;
            if (e.je) m_flush++;
         end
      end
   end

   task automatic idle_in();
      rst = 1'b0; sreq = '0; redir = 1'b0; raddr = '0;
      mcs = 1'b0; mcd = 1'b0; hreq = 1'b0; res = 1'b0;
   endtask

   task automatic step(input logic [4:0] st, input logic [4:0] fl,
                       input logic spc, input logic j,
                       input logic [31:0] ja, input logic hl);
      exp_t e;
      e = '{rst, st, fl, spc, j, ja, hl, exp_tmo};
      q.push_back(e);
      @(negedge clk);
      @(posedge clk);
      #1;
      idle_in();
   endtask

   task automatic idle_step();
      step(5'b0, 5'b0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic mc_step();
      step(5'b00111, 5'b01000, 1'b1, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic halt_step();
      step(5'b11111, 5'b0, 1'b1, 1'b0, 32'h0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      idle_in();
      rst = 1'b1;
      step(5'b0, 5'b11111, 1'b0, 1'b0, 32'h0, 1'b0);
      rst = 1'b1;
      step(5'b0, 5'b11111, 1'b0, 1'b0, 32'h0, 1'b0);
      idle_step();

      sreq = 5'b00010;
      step(5'b00011, 5'b00100, 1'b1, 1'b0, 32'h0, 1'b0);
      idle_step();

      redir = 1'b1; raddr = 32'h80000040;
      step(5'b0, 5'b00011, 1'b0, 1'b1, 32'h80000040, 1'b0);
      idle_step();

      for (int i = 0; i < 3; i++) begin
         sreq = 5'b01000;
         if (i == 0) begin redir = 1'b1; raddr = 32'h80000100; end
         step(5'b01111, 5'b10000, 1'b1, 1'b0, 32'h0, 1'b0);
      end
      step(5'b0, 5'b00011, 1'b0, 1'b1, 32'h80000100, 1'b0);
      idle_step();

      sreq = 5'b00010; redir = 1'b1; raddr = 32'h80000180;
      step(5'b0, 5'b00111, 1'b0, 1'b1, 32'h80000180, 1'b0);
      sreq = 5'b00100; redir = 1'b1; raddr = 32'h800001c0;
      step(5'b00111, 5'b01000, 1'b1, 1'b0, 32'h0, 1'b0);
      step(5'b0, 5'b00011, 1'b0, 1'b1, 32'h800001c0, 1'b0);
      idle_step();

      sreq = 5'b10000; redir = 1'b1; raddr = 32'h80000300;
      step(5'b11111, 5'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      sreq = 5'b10000; redir = 1'b1; raddr = 32'h80000340;
      step(5'b11111, 5'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      step(5'b0, 5'b00011, 1'b0, 1'b1, 32'h80000340, 1'b0);
      idle_step();

      mcs = 1'b1;
      mc_step();
      for (int i = 1; i < 10; i++) mc_step();
      mcd = 1'b1;
      idle_step();
      idle_step();

      mcs = 1'b1;
      mc_step();
      for (int i = 0; i < TMO; i++) mc_step();
      exp_tmo = 1'b1;
      idle_step();
      idle_step();

      mcs = 1'b1; mcd = 1'b1;
      idle_step();
      idle_step();

      mcs = 1'b1;
      mc_step();
      mc_step();
      hreq = 1'b1;
      mc_step();
      mc_step();
      mc_step();
      mcd = 1'b1;
      idle_step();
      halt_step();
      redir = 1'b1; raddr = 32'h80000200;
      halt_step();
      hreq = 1'b1; res = 1'b1;
      halt_step();
      res = 1'b1;
      halt_step();
      step(5'b0, 5'b00011, 1'b0, 1'b1, 32'h80000200, 1'b0);
      idle_step();

      hreq = 1'b1;
      idle_step();
      halt_step();
      rst = 1'b1;
      step(5'b0, 5'b11111, 1'b0, 1'b0, 32'h0, 1'b1);
      exp_tmo = 1'b0;
      idle_step();

      mcs = 1'b1;
      mc_step();
      rst = 1'b1;
      step(5'b0, 5'b11111, 1'b0, 1'b0, 32'h0, 1'b0);
      idle_step();
      idle_step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_seq.md
Name: pipe_ctrl_seq

Overview:
- Parametrised, stateful successor to the combinational pipeline controller of the 5-stage core.
- Generates per-stage stall and flush vectors, plus the PC stall and redirect.
- Sources: arbitrary per-stage stall requests, a redirect source with a pending-redirect buffer, a multi-cycle EXE unit with timeout, and a sticky halt/resume.
- Includes cycle, stall and flush performance counters.
- Sits between the PC/IF/ID/EXE/MEM/WB stages and the core top.

Parameters:
- XLEN, 32, address width.
- NSTAGE, 5, number of pipeline stages; index 0=IF, 1=ID, 2=EXE, 3=MEM, 4=WB.
- EXE_IDX, 2, stage that hosts the multi-cycle unit.
- REDIR_IDX, 2, stage that issues redirect_i.
- MC_TIMEOUT, 64, maximum MC_BUSY cycles before forced abort.
- CNT_W, 32, performance counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- stall_req_i  in  NSTAGE  bit k: stage k cannot advance this cycle (e.g. load-use = bit 1).
- redirect_i  in  1  one-cycle pulse, jump/branch taken at REDIR_IDX.
- redirect_addr_i  in  XLEN  target address, valid with redirect_i.
- mc_start_i  in  1  multi-cycle op starts in EXE_IDX.
- mc_done_i  in  1  multi-cycle op result valid.
- halt_req_i  in  1  halt request (ISA-test halt).
- resume_i  in  1  leave HALTED.
- stallpc_o  out  1  hold PC.
- stall_o  out  NSTAGE  hold stage k.
- flush_o  out  NSTAGE  clear stage k to bubble.
- je_o  out  1  PC redirect enable.
- jump_addr_o  out  XLEN  PC redirect target.
- halted_o  out  1  FSM in HALTED.
- mc_timeout_o  out  1  sticky: multi-cycle op timed out.
- cyc_cnt_o  out  CNT_W  non-halted cycles.
- stall_cnt_o  out  CNT_W  cycles with stallpc_o=1 outside HALTED.
- flush_cnt_o  out  CNT_W  cycles with je_o=1.

Behaviour:

Reset:
- While rst_i=1: flush_o all ones; stall_o=0, stallpc_o=0, je_o=0, jump_addr_o=0.
- At the reset edge: FSM=RUN; pending redirect, halt_pend, busy counter, mc_timeout_o and all counters cleared.
- Reset mid-MC_BUSY or mid-HALTED returns to RUN with no residual stall.

FSM states: RUN, MC_BUSY, HALTED.
- RUN -> MC_BUSY on mc_start_i & !mc_done_i.
- MC_BUSY -> RUN on mc_done_i, or after MC_TIMEOUT cycles in MC_BUSY; the timeout also sets mc_timeout_o.
- RUN -> HALTED on halt_req_i, or when halt_pend=1.
- halt_req_i in MC_BUSY sets halt_pend; MC_BUSY exits to HALTED instead of RUN.
- HALTED -> RUN on resume_i; halt_req_i and resume_i together keep HALTED.

Effective stall vector (combinational):
- S = stall_req_i, plus bit EXE_IDX when (RUN & mc_start_i & !mc_done_i) or (MC_BUSY & !mc_done_i).
- s = highest set index in S.
- If S≠0: stall_o[j]=1 for j≤s; stallpc_o=1; flush_o[s+1]=1 if s+1<NSTAGE (bubble).

Redirect:
- The redirect is eligible when redirect_i or pend_v is set, and either S=0 or s<REDIR_IDX.
- When eligible:
  - je_o=1.
  - jump_addr_o = redirect_addr_i if redirect_i, else the pending address.
  - flush_o[j]=1 for all j<REDIR_IDX.
  - stall_o[j]=0 for j<REDIR_IDX; stallpc_o=0.
  - pend_v cleared.
- If redirect_i arrives while s≥REDIR_IDX: the address is captured in the pending register and pend_v set.
- A newer redirect_i overwrites the pending address.
- Exactly one je_o cycle per redirect.

HALTED:
- stall_o all ones, stallpc_o=1, flush_o=0, je_o=0.
- Pending redirect retained and issued after resume.

Counters:
- All counters wrap modulo 2^CNT_W and are updated at the clock edge.
- cyc_cnt_o and stall_cnt_o are frozen in HALTED.

Test Plan:
1. rst_i=1 for 2 cycles -> flush_o=5'b11111, stall_o=0, je_o=0, all counters 0; release -> flush_o=0.
2. stall_req_i=5'b00010 for 1 cycle (load-use) -> stall_o=5'b00011, stallpc_o=1, flush_o=5'b00100; stall_cnt_o=1 afterwards.
3. Redirect, no stalls: redirect_i=1, redirect_addr_i=0x80000040 -> same cycle je_o=1, jump_addr_o=0x80000040, flush_o=5'b00011; flush_cnt_o=1.
4. Redirect during MEM stall: stall_req_i[3]=1 in cycles t..t+2, redirect_i pulse at t with 0x80000100.
   -> je_o=0 in t..t+2; stall_o=5'b01111 and flush_o=5'b10000 in t..t+2.
   -> je_o=1, jump_addr_o=0x80000100 only in t+3.
5. Multi-cycle op: mc_start_i at t, mc_done_i at t+10 -> stall_o=5'b00111 and flush_o=5'b01000 in t..t+9; released at t+10.
   Repeat with MC_TIMEOUT=8 and no done -> mc_timeout_o=1 and FSM=RUN after 8 MC_BUSY cycles.
6. Halt during MC_BUSY: halt_req_i at t+2, mc_done_i at t+5 -> halted_o=1 from t+6, stall_o=5'b11111, cyc_cnt_o frozen.
   resume_i -> halted_o=0 next cycle; counting resumes.
